// File: rtl/mem_arbiter_rr.sv
// Multi-port cacheline arbiter in front of a single memory port.
// Default policy is fixed priority; define ARB_ROUND_ROBIN_EN for round-robin.
//
// state   | meaning
// IDLE    | no transaction, arbitrate among requesting ports
// BUSY    | latched request presented to memory, waiting for mem_resp
// RELEASE | one dead cycle so the served port can drop its request
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [LINE_WIDTH-1:0]            port_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [LINE_WIDTH-1:0]            mem_wdata,
  input  logic [LINE_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_resp
);

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state;
  logic [GW-1:0]           grant;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           winner;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   rdata_q;
  logic                    write_q;
  logic [NUM_PORTS-1:0]    req;
  logic                    any_req;
  logic                    resp_hit;

  assign req     = port_read | port_write;
  assign any_req = |req;

`ifdef ARB_ROUND_ROBIN_EN
  // Search upward from the port after the previous winner, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      logic [GW-1:0] idx;
      idx = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      logic [GW-1:0] idx;
      idx = GW'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // last_grant is kept up to date but has no effect on fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_PORTS - 1);
      grant      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            addr_q     <= port_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q    <= port_wdata[winner*LINE_WIDTH +: LINE_WIDTH];
            // A port asserting both read and write is served as a write.
            write_q    <= port_write[winner];
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            rdata_q <= mem_rdata;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion is recognised only while a transaction is outstanding.
  assign resp_hit = (state == BUSY) && mem_resp && !rst;

  always_comb begin
    port_resp = '0;
    if (resp_hit) begin
      port_resp[grant] = 1'b1;
    end
  end

  assign port_rdata  = resp_hit ? mem_rdata : rdata_q;
  assign mem_read    = (state == BUSY) && !write_q && !mem_resp;
  assign mem_write   = (state == BUSY) &&  write_q && !mem_resp;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed scoreboard bench for mem_arbiter_rr with four ports and a simple memory model.
// Expected winners follow ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_mem_arbiter_rr;
  localparam int NP = 4;
  localparam int LW = 256;
  localparam int AW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_read;
  logic [NP-1:0]     port_write;
  logic [NP*AW-1:0]  port_address;
  logic [NP*LW-1:0]  port_wdata;
  logic [NP-1:0]     port_resp;
  logic [LW-1:0]     port_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [AW-1:0]     mem_address;
  logic [LW-1:0]     mem_wdata;
  logic [LW-1:0]     mem_rdata;
  logic              mem_resp;

  mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_resp(port_resp), .port_rdata(port_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    logic        wr;
    logic [LW-1:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_lg;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NP-1:0] r, input int lg);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++) if (r[2'((lg + k) % NP)]) return (lg + k) % NP;
`else
    for (int k = 0; k < NP; k++) if (r[2'(k)]) return k;
`endif
    return -1;
  endfunction

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [LW-1:0] wd);
    port_read[p]            = rd;
    port_write[p]           = wr;
    port_address[p*AW +: AW] = a;
    port_wdata[p*LW +: LW]   = wd;
  endtask

  task automatic clear_ports();
    port_read    = '0;
    port_write   = '0;
    port_address = '0;
    port_wdata   = '0;
  endtask

  // Predict the next n grants from the currently driven requests.
  task automatic push_grants(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.port   = model_pick(port_read | port_write, model_lg);
      model_lg = e.port;
      e.addr   = port_address[e.port*AW +: AW];
      e.wr     = port_write[e.port];
      e.wdata  = port_wdata[e.port*LW +: LW];
      sb.push_back(e);
    end
  endtask

  // Entered at the negedge of an IDLE cycle with requests driven; returns at the RELEASE negedge.
  task automatic do_txn(input int lat, input logic [LW-1:0] line, input bit disturb);
    exp_t e;
    logic [NP-1:0] onehot;
    #1;
    check("idle_no_mem_req", {mem_read, mem_write}, 2'b00);
    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb[0];
    for (int c = 0; c < lat; c++) begin
      @(negedge clk); #1;
      check("busy_mem_read", mem_read, !e.wr);
      check("busy_mem_write", mem_write, e.wr);
      check("busy_mem_address", mem_address, e.addr);
      check("busy_mem_wdata", mem_wdata, e.wdata);
      check("busy_port_resp", port_resp, '0);
      if (disturb && c == 0) begin
        port_address = ~port_address;
        port_wdata   = ~port_wdata;
      end
    end
    @(negedge clk);
    mem_resp  = 1'b1;
    mem_rdata = line;
    #1;
    e = sb.pop_front();
    onehot = NP'(1) << e.port;
    check("resp_port_resp", port_resp, onehot);
    check("resp_port_rdata", port_rdata, line);
    check("resp_mem_op_off", {mem_read, mem_write}, 2'b00);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = ~line;
    #1;
    check("release_port_resp", port_resp, '0);
    check("release_no_mem_req", {mem_read, mem_write}, 2'b00);
    check("release_rdata_hold", port_rdata, line);
  endtask

  initial begin
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    rst       = 1'b1;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    clear_ports();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_port_resp", port_resp, '0);
    check("rst_mem_address", mem_address, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_port_rdata", port_rdata, '0);
    @(negedge clk);
    rst      = 1'b0;
    model_lg = NP - 1;

    // Wrap-around from last_grant=3 with ports 0 and 2 requesting.
    set_port(0, 1'b1, 1'b0, 32'h0000_0100, {8{32'h0101_0101}});
    set_port(2, 1'b1, 1'b0, 32'h0000_0300, {8{32'h0303_0303}});
    push_grants(2);
    do_txn(2, {8{32'h1111_1111}}, 1'b0);
    @(negedge clk);
    do_txn(2, {8{32'h2222_2222}}, 1'b0);
    clear_ports();
    @(negedge clk);

    // Single read from port 1.
    set_port(1, 1'b1, 1'b0, 32'h0000_1000, '0);
    push_grants(1);
    do_txn(4, a5, 1'b0);
    clear_ports();
    @(negedge clk);

    // Ports 0 and 1 requesting continuously.
    set_port(0, 1'b1, 1'b0, 32'h0000_0A00, {8{32'hAAAA_0000}});
    set_port(1, 1'b1, 1'b0, 32'h0000_0B00, {8{32'hBBBB_0000}});
    push_grants(4);
    for (int i = 0; i < 4; i++) begin
      do_txn(1 + i, {8{32'hC0DE_0000 + i}}, 1'b0);
      if (i < 3) @(negedge clk);
    end
    clear_ports();
    @(negedge clk);

    // Read+write on port 0 is served as a write; inputs change during BUSY.
    set_port(0, 1'b1, 1'b1, 32'h0000_0040, {8{32'h5A5A_F00D}});
    push_grants(1);
    do_txn(3, {8{32'h7777_7777}}, 1'b1);
    clear_ports();
    @(negedge clk);

    // Reset two cycles into BUSY, then a stale mem_resp.
    set_port(2, 1'b1, 1'b0, 32'h0000_0200, {8{32'h2020_2020}});
    @(negedge clk); #1;
    check("rstbusy_mem_read", mem_read, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    clear_ports();
    @(negedge clk);
    rst       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = {8{32'hDEAD_BEEF}};
    model_lg  = NP - 1;
    #1;
    check("stale_port_resp", port_resp, '0);
    check("stale_mem_op", {mem_read, mem_write}, 2'b00);
    check("stale_mem_address", mem_address, '0);
    check("stale_mem_wdata", mem_wdata, '0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    check("after_stale_idle", {mem_read, mem_write}, 2'b00);
    set_port(0, 1'b1, 1'b0, 32'h0000_0010, '0);
    set_port(3, 1'b1, 1'b0, 32'h0000_0030, '0);
    push_grants(1);
    do_txn(2, {8{32'h3333_3333}}, 1'b0);
    clear_ports();
    @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
